fwd_hazard_ctl: RTL

//  Producer of the execute-stage forwarding controls (forward_XX_A/B, forward_XM_A/B, forward_XX_sel, forward_XM_sel).

---
 rtl/fwd_hazard_ctl_pkg.sv | 25 ++
 rtl/fwd_hazard_ctl_stage_rec.sv | 34 +++
 rtl/fwd_hazard_ctl.sv | 118 +++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctl_pkg.sv
// Shared decode/execute definitions: result-source codes, register width and
// the writer record tracked for each in-flight instruction.
package fwd_hazard_ctl_pkg;

    localparam int REG_AW = 3;

    localparam logic [1:0] SRC_SPEC  = 2'b00;
    localparam logic [1:0] SRC_PCINC = 2'b01;
    localparam logic [1:0] SRC_LOAD  = 2'b10;
    localparam logic [1:0] SRC_ALU   = 2'b11;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_reg;
        logic [1:0]        res_src;
    } hz_rec_t;

    localparam int REC_W = $bits(hz_rec_t);

    function automatic logic rec_writes(hz_rec_t rec, logic [REG_AW-1:0] r);
        return rec.valid & rec.wr_en & (rec.wr_reg == r);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctl_stage_rec.sv
// One pipeline writer record: loads d_i on en_i, or an all-zero bubble when
// bubble_i is also set; holds otherwise.
module hz_stage_rec
    import fwd_hazard_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             bubble_i,
    input  logic [REC_W-1:0] d_i,
    output logic [REC_W-1:0] q_o
);

    logic [REC_W-1:0] rec_q;
    logic [REC_W-1:0] rec_d;

    always_comb begin
        rec_d = rec_q;
        if (en_i) begin
            rec_d = bubble_i ? '0 : d_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign q_o = rec_q;

endmodule

// File: rtl/fwd_hazard_ctl.sv
// Execute-stage forwarding controls and load-use stall, computed in decode
// from the writer records of the instructions in ID/EX, EX/MEM and MEM/WB.
module fwd_hazard_ctl
    import fwd_hazard_ctl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_rs_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rt_valid,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic [1:0]        id_res_src,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              forward_XX_A,
    output logic              forward_XX_B,
    output logic              forward_XM_A,
    output logic              forward_XM_B,
    output logic [1:0]        forward_XX_sel,
    output logic [1:0]        forward_XM_sel,
    output logic              stall_id,
    output logic [REC_W-1:0]  dbg_mw_o
);

    hz_rec_t dx_q, xm_q, mw_q, id_rec;
    logic    advance, dx_bubble;
    logic    xx_a, xm_a, xx_b, xm_b, load_use;

    assign id_rec = '{valid: id_valid, wr_en: id_wr_en, wr_reg: id_wr_reg, res_src: id_res_src};

    // Youngest writer wins: an EX/MEM match suppresses the MEM/WB match.
    assign xx_a = id_rs_valid & rec_writes(dx_q, id_rs);
    assign xm_a = id_rs_valid & rec_writes(xm_q, id_rs) & ~xx_a;
    assign xx_b = id_rt_valid & rec_writes(dx_q, id_rt);
    assign xm_b = id_rt_valid & rec_writes(xm_q, id_rt) & ~xx_b;

    assign load_use  = (xx_a | xx_b) & (dx_q.res_src == SRC_LOAD);
    assign stall_id  = load_use & ~flush & id_valid;
    assign advance   = ~mem_stall;
    assign dx_bubble = ~(id_valid & ~stall_id & ~flush);

    hz_stage_rec u_dx (
        .clk(clk), .rst(rst), .en_i(advance), .bubble_i(dx_bubble),
        .d_i(id_rec), .q_o(dx_q)
    );
    hz_stage_rec u_xm (
        .clk(clk), .rst(rst), .en_i(advance), .bubble_i(1'b0),
        .d_i(dx_q), .q_o(xm_q)
    );
    hz_stage_rec u_mw (
        .clk(clk), .rst(rst), .en_i(advance), .bubble_i(1'b0),
        .d_i(xm_q), .q_o(mw_q)
    );

    // MW matches are served by the register-file bypass; the record is only observed.
    assign dbg_mw_o = mw_q;

    logic       fxx_a_q, fxx_b_q, fxm_a_q, fxm_b_q;
    logic       fxx_a_d, fxx_b_d, fxm_a_d, fxm_b_d;
    logic [1:0] xx_sel_q, xm_sel_q, xx_sel_d, xm_sel_d;

    // Selects are zeroed when their path does not forward, so a non-forwarding
    // load sitting in DX can never surface as an XX select of 10.
    always_comb begin
        fxx_a_d  = fxx_a_q;
        fxx_b_d  = fxx_b_q;
        fxm_a_d  = fxm_a_q;
        fxm_b_d  = fxm_b_q;
        xx_sel_d = xx_sel_q;
        xm_sel_d = xm_sel_q;
        if (advance) begin
            if (dx_bubble) begin
                fxx_a_d  = 1'b0;
                fxx_b_d  = 1'b0;
                fxm_a_d  = 1'b0;
                fxm_b_d  = 1'b0;
                xx_sel_d = 2'b00;
                xm_sel_d = 2'b00;
            end else begin
                fxx_a_d  = xx_a;
                fxx_b_d  = xx_b;
                fxm_a_d  = xm_a;
                fxm_b_d  = xm_b;
                xx_sel_d = (xx_a | xx_b) ? dx_q.res_src : 2'b00;
                xm_sel_d = (xm_a | xm_b) ? xm_q.res_src : 2'b00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fxx_a_q  <= 1'b0;
            fxx_b_q  <= 1'b0;
            fxm_a_q  <= 1'b0;
            fxm_b_q  <= 1'b0;
            xx_sel_q <= 2'b00;
            xm_sel_q <= 2'b00;
        end else begin
            fxx_a_q  <= fxx_a_d;
            fxx_b_q  <= fxx_b_d;
            fxm_a_q  <= fxm_a_d;
            fxm_b_q  <= fxm_b_d;
            xx_sel_q <= xx_sel_d;
            xm_sel_q <= xm_sel_d;
        end
    end

    assign forward_XX_A   = fxx_a_q;
    assign forward_XX_B   = fxx_b_q;
    assign forward_XM_A   = fxm_a_q;
    assign forward_XM_B   = fxm_b_q;
    assign forward_XX_sel = xx_sel_q;
    assign forward_XM_sel = xm_sel_q;

endmodule
